// File: rtl/hazard_ctrl_pkg.sv
// Shared encodings for the pipeline hazard controller: forwarding selects
// and sequencer states.
package hazard_ctrl_pkg;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_WB  = 2'b01;
    localparam logic [1:0] FWD_MEM = 2'b10;

    typedef enum logic {
        RUN     = 1'b0,
        MD_BUSY = 1'b1
    } state_t;

    // MEM is the younger producer, so it beats WB when both match.
    function automatic logic [1:0] fwd_sel(input logic mem_hit, input logic wb_hit);
        if (mem_hit)
            return FWD_MEM;
        else if (wb_hit)
            return FWD_WB;
        else
            return FWD_REG;
    endfunction

endpackage

// File: rtl/hazard_ctrl_sat_counter.sv
// Saturating up-counter with synchronous clear (clear beats increment)
// and asynchronous active-low reset.
module sat_counter #(
    parameter int W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] count
);

    always_ff @(posedge clk or negedge reset) begin
        if (!reset)
            count <= '0;
        else if (clr)
            count <= '0;
        else if (inc && (count != '1))
            count <= count + 1'b1;
    end

endmodule

// File: rtl/hazard_ctrl.sv
// Pipeline sequencer for the 5-stage core: load-use stalls, redirect
// flushes, mul/div hold with watchdog, operand forwarding and perf counters.
module hazard_ctrl
    import hazard_ctrl_pkg::*;
#(
    parameter int REG_W      = 5,
    parameter int CNT_W      = 32,
    parameter int MD_TIMEOUT = 64
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [REG_W-1:0] Rs1D,
    input  logic [REG_W-1:0] Rs2D,
    input  logic [REG_W-1:0] Rs1E,
    input  logic [REG_W-1:0] Rs2E,
    input  logic [REG_W-1:0] RD_E,
    input  logic             MemReadE,
    input  logic [REG_W-1:0] RD_M,
    input  logic             RegWriteM,
    input  logic [REG_W-1:0] RD_W,
    input  logic             RegWriteW,
    input  logic             PCSrcE,
    input  logic             MdStartE,
    input  logic             MdDoneE,
    input  logic             CntClr,
    output logic             StallF,
    output logic             StallD,
    output logic             StallE,
    output logic             FlushD,
    output logic             FlushE,
    output logic             FlushM,
    output logic [1:0]       ForwardAE,
    output logic [1:0]       ForwardBE,
    output logic [CNT_W-1:0] StallCnt,
    output logic [CNT_W-1:0] FlushCnt,
    output logic             MdTimeout,
    output logic             state_dbg
);

    localparam int WD_W = $clog2(MD_TIMEOUT + 1);

    state_t            state;
    state_t            state_nxt;
    logic [WD_W-1:0]   wd_cnt;
    logic [WD_W-1:0]   wd_inc;
    logic              wd_hit;
    logic              md_enter;
    logic              load_use;
    logic              flush_inc;
    logic              md_timeout_q;

    assign load_use = MemReadE && (RD_E != '0) && ((RD_E == Rs1D) || (RD_E == Rs2D));
    assign md_enter = (state == RUN) && MdStartE && !MdDoneE;
    assign wd_inc   = wd_cnt + WD_W'(1);
    assign wd_hit   = (state == MD_BUSY) && (wd_inc == WD_W'(MD_TIMEOUT));

    assign MdTimeout = md_timeout_q;
    assign state_dbg = logic'(state);

    always_comb begin
        state_nxt = state;
        StallF    = 1'b0;
        StallD    = 1'b0;
        StallE    = 1'b0;
        FlushD    = 1'b0;
        FlushE    = 1'b0;
        FlushM    = 1'b0;
        flush_inc = 1'b0;
        ForwardAE = FWD_REG;
        ForwardBE = FWD_REG;

        if (!reset) begin
            // Bubble every stage register while the core is held in reset.
            FlushD = 1'b1;
            FlushE = 1'b1;
            FlushM = 1'b1;
        end else begin
            ForwardAE = fwd_sel(RegWriteM && (RD_M != '0) && (RD_M == Rs1E),
                                RegWriteW && (RD_W != '0) && (RD_W == Rs1E));
            ForwardBE = fwd_sel(RegWriteM && (RD_M != '0) && (RD_M == Rs2E),
                                RegWriteW && (RD_W != '0) && (RD_W == Rs2E));
            case (state)
                RUN: begin
                    if (MdStartE && !MdDoneE) begin
                        StallF    = 1'b1;
                        StallD    = 1'b1;
                        StallE    = 1'b1;
                        FlushM    = 1'b1;
                        state_nxt = MD_BUSY;
                    end else if (MdStartE) begin
                        // Single-cycle mul/div: proceeds like any ALU op.
                        state_nxt = RUN;
                    end else if (PCSrcE) begin
                        // Redirect squashes the ID instruction, so any load-use is moot.
                        FlushD    = 1'b1;
                        FlushE    = 1'b1;
                        flush_inc = 1'b1;
                    end else if (load_use) begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        FlushE = 1'b1;
                    end
                end
                MD_BUSY: begin
                    if (MdDoneE) begin
                        state_nxt = RUN;
                    end else begin
                        StallF = 1'b1;
                        StallD = 1'b1;
                        StallE = 1'b1;
                        FlushM = 1'b1;
                    end
                end
                default: state_nxt = RUN;
            endcase
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state        <= RUN;
            wd_cnt       <= '0;
            md_timeout_q <= 1'b0;
        end else begin
            state <= state_nxt;
            // Watchdog saturates at MD_TIMEOUT; the flag is what stays sticky.
            if (md_enter)
                wd_cnt <= WD_W'(1);
            else if ((state == MD_BUSY) && (wd_cnt != WD_W'(MD_TIMEOUT)))
                wd_cnt <= wd_inc;
            if (CntClr)
                md_timeout_q <= 1'b0;
            else if (wd_hit)
                md_timeout_q <= 1'b1;
        end
    end

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (StallF),
        .clr   (CntClr),
        .count (StallCnt)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (flush_inc),
        .clr   (CntClr),
        .count (FlushCnt)
    );

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: reset, load-use, redirect, forwarding,
// mul/div hold, watchdog/saturation and reset during a mul/div hold.
module tb_hazard_ctrl;

    localparam int REG_W      = 5;
    localparam int CNT_W      = 4;
    localparam int MD_TIMEOUT = 8;

    logic             clk;
    logic             reset;
    logic [REG_W-1:0] Rs1D, Rs2D, Rs1E, Rs2E, RD_E, RD_M, RD_W;
    logic             MemReadE, RegWriteM, RegWriteW, PCSrcE, MdStartE, MdDoneE, CntClr;
    logic             StallF, StallD, StallE, FlushD, FlushE, FlushM;
    logic [1:0]       ForwardAE, ForwardBE;
    logic [CNT_W-1:0] StallCnt, FlushCnt;
    logic             MdTimeout;
    logic             state_dbg;

    // {StallF, StallD, StallE, FlushD, FlushE, FlushM}
    logic [5:0] ctl;
    assign ctl = {StallF, StallD, StallE, FlushD, FlushE, FlushM};

    int vec_cnt = 0;
    int err_cnt = 0;
    logic [5:0] exp_q[$];

    hazard_ctrl #(.REG_W(REG_W), .CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clk(clk), .reset(reset),
        .Rs1D(Rs1D), .Rs2D(Rs2D), .Rs1E(Rs1E), .Rs2E(Rs2E),
        .RD_E(RD_E), .MemReadE(MemReadE),
        .RD_M(RD_M), .RegWriteM(RegWriteM),
        .RD_W(RD_W), .RegWriteW(RegWriteW),
        .PCSrcE(PCSrcE), .MdStartE(MdStartE), .MdDoneE(MdDoneE), .CntClr(CntClr),
        .StallF(StallF), .StallD(StallD), .StallE(StallE),
        .FlushD(FlushD), .FlushE(FlushE), .FlushM(FlushM),
        .ForwardAE(ForwardAE), .ForwardBE(ForwardBE),
        .StallCnt(StallCnt), .FlushCnt(FlushCnt),
        .MdTimeout(MdTimeout), .state_dbg(state_dbg)
    );

    // Clock / reset
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    // Driver tasks
    task automatic idle();
        Rs1D = '0; Rs2D = '0; Rs1E = '0; Rs2E = '0;
        RD_E = '0; RD_M = '0; RD_W = '0;
        MemReadE = 1'b0; RegWriteM = 1'b0; RegWriteW = 1'b0;
        PCSrcE = 1'b0; MdStartE = 1'b0; MdDoneE = 1'b0; CntClr = 1'b0;
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_counters();
        CntClr = 1'b1;
        tick();
        CntClr = 1'b0;
    endtask

    task automatic test_reset();
        idle();
        reset = 1'b0;
        Rs1E = 5'd7; RD_M = 5'd7; RegWriteM = 1'b1;
        #2;
        vec_cnt++;
        if (ctl !== 6'b000111) begin err_cnt++; $display("FAIL reset_ctl: got %b expected %b", ctl, 6'b000111); end
        vec_cnt++;
        if (ForwardAE !== 2'b00) begin err_cnt++; $display("FAIL reset_fwd: got %b expected 00", ForwardAE); end
        vec_cnt++;
        if ({StallCnt, FlushCnt, MdTimeout, state_dbg} !== '0) begin
            err_cnt++; $display("FAIL reset_regs: got %h/%h/%b/%b expected all zero", StallCnt, FlushCnt, MdTimeout, state_dbg);
        end
        tick();
        idle();
        reset = 1'b1;
        tick();
        vec_cnt++;
        if (ctl !== 6'b000000) begin err_cnt++; $display("FAIL post_reset_ctl: got %b expected 000000", ctl); end
    endtask

    task automatic test_load_use();
        idle();
        MemReadE = 1'b1; RD_E = 5'd5; Rs1D = 5'd5;
        #1;
        vec_cnt++;
        if (ctl !== 6'b110010) begin err_cnt++; $display("FAIL lu_rs1_ctl: got %b expected 110010", ctl); end
        tick();
        vec_cnt++;
        if (StallCnt !== 4'd1) begin err_cnt++; $display("FAIL lu_stallcnt1: got %0d expected 1", StallCnt); end
        RD_E = 5'd0;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000) begin err_cnt++; $display("FAIL lu_x0_ctl: got %b expected 000000", ctl); end
        Rs1D = 5'd0;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000) begin err_cnt++; $display("FAIL lu_x0_both_ctl: got %b expected 000000", ctl); end
        tick();
        vec_cnt++;
        if (StallCnt !== 4'd1) begin err_cnt++; $display("FAIL lu_stallcnt_hold: got %0d expected 1", StallCnt); end
        RD_E = 5'd9; Rs1D = 5'd3; Rs2D = 5'd9;
        #1;
        vec_cnt++;
        if (ctl !== 6'b110010) begin err_cnt++; $display("FAIL lu_rs2_ctl: got %b expected 110010", ctl); end
        MemReadE = 1'b0;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000) begin err_cnt++; $display("FAIL lu_noload_ctl: got %b expected 000000", ctl); end
        MemReadE = 1'b1;
        tick();
        vec_cnt++;
        if (StallCnt !== 4'd2) begin err_cnt++; $display("FAIL lu_stallcnt2: got %0d expected 2", StallCnt); end
        CntClr = 1'b1;
        tick();
        vec_cnt++;
        if (StallCnt !== 4'd0) begin err_cnt++; $display("FAIL clr_priority: got %0d expected 0", StallCnt); end
        idle();
    endtask

    task automatic test_redirect();
        idle();
        clear_counters();
        PCSrcE = 1'b1; MemReadE = 1'b1; RD_E = 5'd5; Rs1D = 5'd5;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000110) begin err_cnt++; $display("FAIL br_lu_ctl: got %b expected 000110", ctl); end
        tick();
        vec_cnt++;
        if ({FlushCnt, StallCnt} !== {4'd1, 4'd0}) begin
            err_cnt++; $display("FAIL br_counts: got flush %0d stall %0d expected 1 0", FlushCnt, StallCnt);
        end
        MemReadE = 1'b0;
        tick();
        vec_cnt++;
        if (FlushCnt !== 4'd2) begin err_cnt++; $display("FAIL br_flushcnt2: got %0d expected 2", FlushCnt); end
        MdStartE = 1'b1; MdDoneE = 1'b1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000) begin err_cnt++; $display("FAIL md1_over_br_ctl: got %b expected 000000", ctl); end
        tick();
        vec_cnt++;
        if ({FlushCnt, state_dbg} !== {4'd2, 1'b0}) begin
            err_cnt++; $display("FAIL md1_over_br_regs: got flush %0d state %b expected 2 0", FlushCnt, state_dbg);
        end
        idle();
    endtask

    task automatic test_forward();
        idle();
        RegWriteM = 1'b1; RD_M = 5'd7; RegWriteW = 1'b1; RD_W = 5'd7; Rs1E = 5'd7; Rs2E = 5'd7;
        #1;
        vec_cnt++;
        if ({ForwardAE, ForwardBE} !== 4'b1010) begin err_cnt++; $display("FAIL fwd_mem_prio: got %b expected 1010", {ForwardAE, ForwardBE}); end
        RegWriteM = 1'b0;
        #1;
        vec_cnt++;
        if ({ForwardAE, ForwardBE} !== 4'b0101) begin err_cnt++; $display("FAIL fwd_wb: got %b expected 0101", {ForwardAE, ForwardBE}); end
        RegWriteM = 1'b1; RD_M = 5'd0; RD_W = 5'd0; Rs1E = 5'd0; Rs2E = 5'd0;
        #1;
        vec_cnt++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin err_cnt++; $display("FAIL fwd_x0: got %b expected 0000", {ForwardAE, ForwardBE}); end
        RD_M = 5'd7; RD_W = 5'd3; Rs1E = 5'd7; Rs2E = 5'd3;
        #1;
        vec_cnt++;
        if ({ForwardAE, ForwardBE} !== 4'b1001) begin err_cnt++; $display("FAIL fwd_mixed: got %b expected 1001", {ForwardAE, ForwardBE}); end
        Rs1E = 5'd4; Rs2E = 5'd8;
        #1;
        vec_cnt++;
        if ({ForwardAE, ForwardBE} !== 4'b0000) begin err_cnt++; $display("FAIL fwd_nomatch: got %b expected 0000", {ForwardAE, ForwardBE}); end
        idle();
    endtask

    task automatic test_md_busy();
        idle();
        clear_counters();
        for (int i = 0; i < 4; i++) exp_q.push_back(6'b111001);
        exp_q.push_back(6'b000000);
        MdStartE = 1'b1;
        for (int c = 0; c < 5; c++) begin
            logic [5:0] exp_ctl;
            if (c == 1) MdStartE = 1'b0;
            // Redirect and load-use in the middle of the hold must be ignored.
            PCSrcE = (c == 2);
            MemReadE = (c == 2); RD_E = 5'd6; Rs1D = 5'd6;
            MdDoneE = (c == 4);
            #1;
            exp_ctl = exp_q.pop_front();
            vec_cnt++;
            if (ctl !== exp_ctl) begin err_cnt++; $display("FAIL md_ctl_c%0d: got %b expected %b", c, ctl, exp_ctl); end
            tick();
        end
        idle();
        vec_cnt++;
        if ({state_dbg, StallCnt, FlushCnt, MdTimeout} !== {1'b0, 4'd4, 4'd0, 1'b0}) begin
            err_cnt++; $display("FAIL md_end_regs: got state %b stall %0d flush %0d to %b expected 0 4 0 0",
                                state_dbg, StallCnt, FlushCnt, MdTimeout);
        end
        MdStartE = 1'b1; MemReadE = 1'b1; RD_E = 5'd6; Rs1D = 5'd6;
        #1;
        vec_cnt++;
        if (ctl !== 6'b111001) begin err_cnt++; $display("FAIL md_over_lu_ctl: got %b expected 111001", ctl); end
        MdDoneE = 1'b1;
        tick();
        idle();
    endtask

    task automatic test_timeout_sat();
        idle();
        clear_counters();
        MdStartE = 1'b1;
        tick();
        MdStartE = 1'b0;
        for (int j = 1; j <= 16; j++) begin
            #1;
            vec_cnt++;
            if ({state_dbg, MdTimeout, ctl} !== {1'b1, (j >= 8), 6'b111001}) begin
                err_cnt++; $display("FAIL to_busy_j%0d: got state %b to %b ctl %b expected 1 %b 111001",
                                    j, state_dbg, MdTimeout, ctl, (j >= 8));
            end
            tick();
        end
        vec_cnt++;
        if (StallCnt !== 4'd15) begin err_cnt++; $display("FAIL stall_sat: got %0d expected 15", StallCnt); end
        MdDoneE = 1'b1;
        #1;
        vec_cnt++;
        if (ctl !== 6'b000000) begin err_cnt++; $display("FAIL to_done_ctl: got %b expected 000000", ctl); end
        tick();
        MdDoneE = 1'b0;
        vec_cnt++;
        if ({state_dbg, MdTimeout, StallCnt} !== {1'b0, 1'b1, 4'd15}) begin
            err_cnt++; $display("FAIL to_sticky: got state %b to %b stall %0d expected 0 1 15", state_dbg, MdTimeout, StallCnt);
        end
        clear_counters();
        vec_cnt++;
        if ({MdTimeout, StallCnt} !== {1'b0, 4'd0}) begin
            err_cnt++; $display("FAIL to_clear: got to %b stall %0d expected 0 0", MdTimeout, StallCnt);
        end
    endtask

    task automatic test_reset_mid_busy();
        idle();
        clear_counters();
        MdStartE = 1'b1;
        tick();
        MdStartE = 1'b0;
        tick();
        vec_cnt++;
        if ({state_dbg, StallCnt} !== {1'b1, 4'd2}) begin
            err_cnt++; $display("FAIL rmb_pre: got state %b stall %0d expected 1 2", state_dbg, StallCnt);
        end
        reset = 1'b0;
        #1;
        vec_cnt++;
        if ({state_dbg, StallCnt, ctl} !== {1'b0, 4'd0, 6'b000111}) begin
            err_cnt++; $display("FAIL rmb_in_reset: got state %b stall %0d ctl %b expected 0 0 000111", state_dbg, StallCnt, ctl);
        end
        tick();
        reset = 1'b1;
        tick();
        vec_cnt++;
        if ({state_dbg, ctl} !== {1'b0, 6'b000000}) begin
            err_cnt++; $display("FAIL rmb_release: got state %b ctl %b expected 0 000000", state_dbg, ctl);
        end
        MemReadE = 1'b1; RD_E = 5'd5; Rs2D = 5'd5;
        #1;
        vec_cnt++;
        if (ctl !== 6'b110010) begin err_cnt++; $display("FAIL rmb_lu_ctl: got %b expected 110010", ctl); end
        tick();
        vec_cnt++;
        if (StallCnt !== 4'd1) begin err_cnt++; $display("FAIL rmb_stallcnt: got %0d expected 1", StallCnt); end
        idle();
    endtask

    initial begin
        test_reset();
        test_load_use();
        test_redirect();
        test_forward();
        test_md_busy();
        test_timeout_sat();
        test_reset_mid_busy();
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline sequencer for the 5-stage RV64 core. Drives stall, flush and forwarding controls for the IF/ID, ID/EXE and EXE/MEM registers.
- Detects load-use hazards and branch/jump redirects.
- Holds the pipeline while the multi-cycle mul/div unit in EXE is busy, with a timeout watchdog.
- Keeps saturating stall and flush performance counters.

Parameters:
REG_W, 5, register address width
CNT_W, 32, performance counter width
MD_TIMEOUT, 64, max cycles in MD_BUSY before MdTimeout sets (must be ≥2)

Ports:
clk  in  1  pipeline clock
reset  in  1  asynchronous, active-low reset (0 = reset asserted)
Rs1D  in  REG_W  rs1 of instruction in ID
Rs2D  in  REG_W  rs2 of instruction in ID
Rs1E  in  REG_W  rs1 of instruction in EXE
Rs2E  in  REG_W  rs2 of instruction in EXE
RD_E  in  REG_W  rd in EXE
MemReadE  in  1  EXE instruction is a load
RD_M  in  REG_W  rd in MEM
RegWriteM  in  1  MEM instruction writes rd
RD_W  in  REG_W  rd in WB
RegWriteW  in  1  WB instruction writes rd
PCSrcE  in  1  taken branch / JAL / JALR resolved in EXE
MdStartE  in  1  mul/div op present in EXE, first cycle
MdDoneE  in  1  mul/div result valid this cycle
CntClr  in  1  synchronous clear of counters and MdTimeout
StallF  out  1  hold PC
StallD  out  1  hold IF/ID
StallE  out  1  hold ID/EXE
FlushD  out  1  bubble IF/ID
FlushE  out  1  bubble ID/EXE
FlushM  out  1  bubble EXE/MEM
ForwardAE  out  2  ALU A select: 00 reg, 01 WB, 10 MEM
ForwardBE  out  2  ALU B select, same encoding
StallCnt  out  CNT_W  cycles with StallF=1
FlushCnt  out  CNT_W  redirects taken
MdTimeout  out  1  sticky watchdog flag

Behaviour:
- FSM states: RUN, MD_BUSY. Stall/flush/forward outputs are combinational from state and inputs, so they act in the same cycle. Counters, flag and state are registered.
- RUN, priority high to low:
  1. MdStartE & !MdDoneE: StallF=StallD=StallE=FlushM=1. Next state MD_BUSY, watchdog counter=1.
  2. MdStartE & MdDoneE: single-cycle op, no stall, stay RUN.
  3. PCSrcE: FlushD=FlushE=1, no stalls, FlushCnt+1.
  4. Load-use: MemReadE & RD_E!=0 & (RD_E==Rs1D | RD_E==Rs2D) gives StallF=StallD=FlushE=1.
  5. Otherwise all stall/flush outputs 0.
- MD_BUSY:
  - Each cycle: StallF=StallD=StallE=FlushM=1. PCSrcE and load-use are ignored.
  - On MdDoneE: all stalls 0 that cycle (result latches into EXE/MEM), next state RUN.
  - Watchdog increments per cycle. On reaching MD_TIMEOUT, MdTimeout sets (sticky) and the FSM stays in MD_BUSY until MdDoneE.
- Forwarding, evaluated in every state, MEM has priority over WB:
  - RegWriteM & RD_M!=0 & RD_M==Rs1E gives ForwardAE=10.
  - Else RegWriteW & RD_W!=0 & RD_W==Rs1E gives 01.
  - Else 00.
  - Same rules for ForwardBE against Rs2E.
  - x0 is never forwarded.
- Counters:
  - StallCnt increments on every cycle StallF=1 and saturates at all-ones.
  - FlushCnt increments once per cycle PCSrcE is honoured (RUN only) and saturates.
  - CntClr has priority over increment in the same cycle: clears both counters and MdTimeout.
- Reset (reset=0, asynchronous):
  - State RUN; watchdog, StallCnt, FlushCnt = 0; MdTimeout = 0.
  - While in reset: StallF=StallD=StallE=0, FlushD=FlushE=FlushM=1, ForwardAE=ForwardBE=00.
  - Reset mid MD_BUSY aborts to RUN; the mul/div unit is reset by the same signal.
- Simultaneous PCSrcE and load-use: redirect wins, with no stall, because the ID instruction is squashed.

Decomposition:
- Shared package: forward-select constants FWD_REG=2'b00, FWD_WB=2'b01, FWD_MEM=2'b10, and state encodings RUN/MD_BUSY.
- One natural sub-module: sat_counter (CNT_W wide, inc, clr), instantiated twice.

Test Plan:
- Load x5 in EXE (MemReadE=1, RD_E=5), Rs1D=5 -> StallF=StallD=FlushE=1 for 1 cycle, StallCnt 0→1. Same stimulus with RD_E=0 -> no stall.
- PCSrcE=1 with load-use also true -> FlushD=FlushE=1, StallF=0, FlushCnt +1.
- RegWriteM=1, RD_M=7, RegWriteW=1, RD_W=7, Rs1E=7 -> ForwardAE=10. With RegWriteM=0 -> 01. With RD_M=RD_W=0 -> 00.
- MdStartE=1, MdDoneE pulsed 4 cycles later -> StallE=FlushM=1 for 4 cycles, 0 on the done cycle. StallCnt=4, state back to RUN.
- MD_TIMEOUT=8 with no MdDoneE for 10 cycles -> MdTimeout=1 from the 8th busy cycle, stays set after done. CntClr clears it.
- Assert reset=0 in the 2nd MD_BUSY cycle -> immediate RUN, counters 0, FlushD/E/M=1 during reset. Release -> normal operation.
